detect_collector: RTL and testbench

//  Collects detection reports (valid pulse + detect_time) from NUM_CH per-microphone

---
 rtl/detect_collector.sv | 197 +++++++++++++++++++
 tb/tb_detect_collector.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/detect_collector.sv
// detect_collector: groups per-channel detection reports into one event frame
// per acoustic event, held for the processor until acknowledged.
module detect_collector #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned TW     = 32,
    parameter int unsigned DROP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic [31:0]            window_len,
    input  logic [4:0]             min_ch,
    input  logic [NUM_CH-1:0]      ch_valid,
    input  logic [NUM_CH*TW-1:0]   ch_time,
    output logic [NUM_CH-1:0]      ch_ack,
    output logic                   frame_valid,
    input  logic                   frame_ack,
    output logic [NUM_CH-1:0]      frame_mask,
    output logic [NUM_CH*TW-1:0]   frame_times,
    output logic                   frame_tmo,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int unsigned PC_W  = 6;
    localparam int unsigned WIN_W = 32;
    localparam int unsigned SUM_W = DROP_W + PC_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_PRESENT = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [NUM_CH-1:0]      mask_q, mask_d;
    logic [NUM_CH*TW-1:0]   times_q, times_d;
    logic                   tmo_q, tmo_d;
    logic                   valid_q, valid_d;
    logic [NUM_CH-1:0]      ack_q, ack_d;
    logic [WIN_W-1:0]       wcnt_q, wcnt_d;
    logic [DROP_W-1:0]      drop_q, drop_d;

    logic [NUM_CH-1:0]      cap;
    logic [NUM_CH-1:0]      drop_bits;
    logic [NUM_CH-1:0]      new_mask;
    logic [NUM_CH*TW-1:0]   times_cap;
    logic [PC_W-1:0]        min_eff;
    logic [SUM_W-1:0]       drop_sum;

    function automatic logic [PC_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // Which reports are captured vs dropped this edge, and the resulting frame contents
    always_comb begin
        cap       = '0;
        drop_bits = '0;
        if (!enable) begin
            drop_bits = ch_valid;
        end else begin
            case (state_q)
                S_IDLE:    cap = ch_valid;
                S_COLLECT: begin
                    cap       = ch_valid & ~mask_q;
                    drop_bits = ch_valid & mask_q;
                end
                S_PRESENT: drop_bits = ch_valid;
                default:   drop_bits = ch_valid;
            endcase
        end
        new_mask  = mask_q | cap;
        times_cap = times_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
                times_cap[i*TW +: TW] = ch_time[i*TW +: TW];
            end
        end
        min_eff  = (min_ch == 5'd0) ? PC_W'(1) : PC_W'(min_ch);
        drop_sum = SUM_W'(drop_q) + SUM_W'(popcount(drop_bits));
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        times_d = times_q;
        tmo_d   = tmo_q;
        valid_d = valid_q;
        wcnt_d  = wcnt_q;
        ack_d   = cap;

        if (drop_sum > SUM_W'({DROP_W{1'b1}})) begin
            drop_d = '1;
        end else begin
            drop_d = drop_sum[DROP_W-1:0];
        end

        if (!enable) begin
            state_d = S_IDLE;
            mask_d  = '0;
            times_d = '0;
            tmo_d   = 1'b0;
            valid_d = 1'b0;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|cap) begin
                        mask_d  = new_mask;
                        times_d = times_cap;
                        tmo_d   = 1'b0;
                        wcnt_d  = '0;
                        if (&new_mask) begin
                            state_d = S_PRESENT;
                            valid_d = 1'b1;
                        end else begin
                            state_d = S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    mask_d  = new_mask;
                    times_d = times_cap;
                    wcnt_d  = wcnt_q + WIN_W'(1);
                    if (&new_mask) begin
                        state_d = S_PRESENT;
                        valid_d = 1'b1;
                        tmo_d   = 1'b0;
                    end else if (wcnt_q >= window_len) begin
                        if (popcount(new_mask) >= min_eff) begin
                            state_d = S_PRESENT;
                            valid_d = 1'b1;
                            tmo_d   = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            mask_d  = '0;
                            times_d = '0;
                            tmo_d   = 1'b0;
                        end
                    end
                end
                S_PRESENT: begin
                    if (frame_ack) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                        mask_d  = '0;
                        times_d = '0;
                        tmo_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    mask_d  = '0;
                    times_d = '0;
                    tmo_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            mask_q  <= '0;
            times_q <= '0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= '0;
            wcnt_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            times_q <= times_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            wcnt_q  <= wcnt_d;
            drop_q  <= drop_d;
        end
    end

    assign ch_ack      = ack_q;
    assign frame_valid = valid_q;
    assign frame_mask  = mask_q;
    assign frame_times = times_q;
    assign frame_tmo   = tmo_q;
    assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_detect_collector.sv
// Testbench for detect_collector: directed scenarios plus randomized episodes
// checked against an event-level reference model.
module tb_detect_collector;

    localparam int unsigned NCH = 4;
    localparam int unsigned TW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [31:0]       window_len;
    logic [4:0]        min_ch;
    logic [NCH-1:0]    ch_valid;
    logic [NCH*TW-1:0] ch_time;
    logic              frame_ack;

    logic [NCH-1:0]    ch_ack,      ch_ack_s;
    logic              frame_valid, frame_valid_s;
    logic [NCH-1:0]    frame_mask,  frame_mask_s;
    logic [NCH*TW-1:0] frame_times, frame_times_s;
    logic              frame_tmo,   frame_tmo_s;
    logic [15:0]       drop_cnt;
    logic [3:0]        drop_cnt_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    detect_collector #(.NUM_CH(NCH), .TW(TW), .DROP_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .window_len(window_len), .min_ch(min_ch),
        .ch_valid(ch_valid), .ch_time(ch_time), .ch_ack(ch_ack), .frame_valid(frame_valid),
        .frame_ack(frame_ack), .frame_mask(frame_mask), .frame_times(frame_times),
        .frame_tmo(frame_tmo), .drop_cnt(drop_cnt)
    );

    detect_collector #(.NUM_CH(NCH), .TW(TW), .DROP_W(4)) dut_sat (
        .clk(clk), .rst(rst), .enable(enable), .window_len(window_len), .min_ch(min_ch),
        .ch_valid(ch_valid), .ch_time(ch_time), .ch_ack(ch_ack_s), .frame_valid(frame_valid_s),
        .frame_ack(frame_ack), .frame_mask(frame_mask_s), .frame_times(frame_times_s),
        .frame_tmo(frame_tmo_s), .drop_cnt(drop_cnt_s)
    );

    function automatic int popc(input logic [NCH-1:0] v);
        int n = 0;
        for (int i = 0; i < NCH; i++) n += int'(v[i]);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int c, input logic [TW-1:0] v);
        ch_time[c*TW +: TW] = v;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; window_len = 32'd100; min_ch = 5'd1;
        ch_valid = '0; ch_time = '0; frame_ack = 1'b0;
        #23;
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv got=%0b exp=0", frame_valid); end
        checks++; if (ch_ack !== 4'h0) begin errors++; $display("FAIL reset_ack got=%h exp=0", ch_ack); end
        checks++; if (frame_mask !== 4'h0 || frame_tmo !== 1'b0) begin errors++; $display("FAIL reset_mask got=%h/%0b exp=0/0", frame_mask, frame_tmo); end
        checks++; if (frame_times !== '0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_times_drop got=%h/%0d exp=0/0", frame_times, drop_cnt); end
        rst = 1'b1;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        window_len = 32'd100; min_ch = 5'd1;
        ch_valid = 4'b0001; set_time(0, 32'h10); tick();
        checks++; if (ch_ack !== 4'b0001 || frame_valid !== 1'b0) begin errors++; $display("FAIL t1_ack0 got=%h fv=%0b exp=1 fv=0", ch_ack, frame_valid); end
        ch_valid = '0; tick();
        checks++; if (ch_ack !== 4'h0) begin errors++; $display("FAIL t1_ack_pulse got=%h exp=0", ch_ack); end
        ch_valid = 4'b0100; set_time(2, 32'h12); tick();
        checks++; if (ch_ack !== 4'b0100) begin errors++; $display("FAIL t1_ack2 got=%h exp=4", ch_ack); end
        ch_valid = '0; tick(); tick();
        ch_valid = 4'b1010; set_time(1, 32'h15); set_time(3, 32'h15); tick();
        checks++; if (ch_ack !== 4'b1010 || frame_valid !== 1'b1) begin errors++; $display("FAIL t1_complete got=%h fv=%0b exp=a fv=1", ch_ack, frame_valid); end
        checks++; if (frame_mask !== 4'hF || frame_tmo !== 1'b0) begin errors++; $display("FAIL t1_mask got=%h tmo=%0b exp=f tmo=0", frame_mask, frame_tmo); end
        checks++; if (frame_times !== {32'h15, 32'h12, 32'h15, 32'h10}) begin errors++; $display("FAIL t1_times got=%h", frame_times); end
        ch_valid = '0; frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        checks++; if (frame_valid !== 1'b0 || frame_mask !== 4'h0 || frame_times !== '0) begin errors++; $display("FAIL t1_ack_clear got fv=%0b mask=%h", frame_valid, frame_mask); end
    endtask

    task automatic test_timeout_keep();
        window_len = 32'd20; min_ch = 5'd2;
        for (int o = 0; o <= 21; o++) begin
            ch_valid = '0;
            if (o == 0) begin ch_valid = 4'b0010; set_time(1, 32'h21); end
            if (o == 3) begin ch_valid = 4'b1000; set_time(3, 32'h23); end
            tick();
            if (o == 20) begin
                checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL t2_early_fv got=1 exp=0"); end
            end
        end
        ch_valid = '0;
        checks++; if (frame_valid !== 1'b1 || frame_mask !== 4'hA || frame_tmo !== 1'b1) begin errors++; $display("FAIL t2_frame got fv=%0b mask=%h tmo=%0b exp 1/a/1", frame_valid, frame_mask, frame_tmo); end
        checks++; if (frame_times[0 +: TW] !== 32'h0 || frame_times[2*TW +: TW] !== 32'h0 || frame_times[TW +: TW] !== 32'h21) begin errors++; $display("FAIL t2_times got=%h", frame_times); end
        tick();
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL t2_hold got fv=0 exp=1"); end
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        checks++; if (frame_valid !== 1'b0 || frame_mask !== 4'h0 || frame_tmo !== 1'b0) begin errors++; $display("FAIL t2_clear got fv=%0b mask=%h tmo=%0b", frame_valid, frame_mask, frame_tmo); end
    endtask

    task automatic test_timeout_discard();
        logic seen_fv;
        seen_fv = 1'b0;
        window_len = 32'd20; min_ch = 5'd3;
        for (int o = 0; o < 25; o++) begin
            ch_valid = (o == 0) ? 4'b0001 : 4'b0000;
            tick();
            if (frame_valid) seen_fv = 1'b1;
        end
        checks++; if (seen_fv !== 1'b0 || frame_mask !== 4'h0) begin errors++; $display("FAIL t3_discard got fv_seen=%0b mask=%h exp 0/0", seen_fv, frame_mask); end
        ch_valid = 4'b0100; set_time(2, 32'h33); tick(); ch_valid = '0;
        checks++; if (ch_ack !== 4'b0100 || frame_mask !== 4'b0100) begin errors++; $display("FAIL t3_reopen got ack=%h mask=%h exp 4/4", ch_ack, frame_mask); end
        enable = 1'b0; tick(); enable = 1'b1;
    endtask

    task automatic test_duplicates();
        logic [15:0] d0;
        window_len = 32'd100; min_ch = 5'd1;
        d0 = drop_cnt;
        ch_valid = 4'b0001; set_time(0, 32'hA0); tick();
        checks++; if (ch_ack !== 4'b0001) begin errors++; $display("FAIL t4_first got=%h exp=1", ch_ack); end
        ch_valid = 4'b0001; set_time(0, 32'hB1); tick();
        checks++; if (ch_ack !== 4'b0000) begin errors++; $display("FAIL t4_dup_ack got=%h exp=0", ch_ack); end
        ch_valid = 4'b1110; tick();
        checks++; if (ch_ack !== 4'b1110 || frame_valid !== 1'b1) begin errors++; $display("FAIL t4_complete got=%h fv=%0b", ch_ack, frame_valid); end
        ch_valid = 4'b0001; set_time(0, 32'hC3); tick();
        checks++; if (ch_ack !== 4'b0000 || frame_times[0 +: TW] !== 32'hA0) begin errors++; $display("FAIL t4_present got ack=%h t0=%h exp 0/a0", ch_ack, frame_times[0 +: TW]); end
        ch_valid = 4'b0001; frame_ack = 1'b1; tick(); frame_ack = 1'b0; ch_valid = '0;
        checks++; if (frame_valid !== 1'b0 || ch_ack !== 4'b0000) begin errors++; $display("FAIL t4_ack got fv=%0b ack=%h", frame_valid, ch_ack); end
        checks++; if (drop_cnt !== d0 + 16'd3) begin errors++; $display("FAIL t4_drops got=%0d exp=%0d", drop_cnt, d0 + 16'd3); end
    endtask

    task automatic test_reset_enable();
        window_len = 32'd100; min_ch = 5'd1;
        ch_valid = 4'b0010; tick(); ch_valid = '0;
        #2 rst = 1'b0; #1;
        checks++; if (ch_ack !== 4'h0 || frame_mask !== 4'h0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL t5_rst_collect got ack=%h mask=%h drop=%0d", ch_ack, frame_mask, drop_cnt); end
        #2 rst = 1'b1;
        ch_valid = 4'hF; set_time(3, 32'h77); tick(); ch_valid = '0;
        checks++; if (frame_valid !== 1'b1 || frame_mask !== 4'hF) begin errors++; $display("FAIL t5_direct got fv=%0b mask=%h exp 1/f", frame_valid, frame_mask); end
        #2 rst = 1'b0; #1;
        checks++; if (frame_valid !== 1'b0 || frame_mask !== 4'h0 || frame_times !== '0) begin errors++; $display("FAIL t5_rst_present got fv=%0b mask=%h", frame_valid, frame_mask); end
        #2 rst = 1'b1;
        ch_valid = 4'b0001; tick();
        ch_valid = 4'b0001; tick(); ch_valid = '0;
        enable = 1'b0; tick();
        checks++; if (frame_mask !== 4'h0 || frame_valid !== 1'b0 || ch_ack !== 4'h0) begin errors++; $display("FAIL t5_enable got mask=%h fv=%0b ack=%h", frame_mask, frame_valid, ch_ack); end
        checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL t5_enable_drop got=%0d exp=1", drop_cnt); end
        enable = 1'b1;
        ch_valid = 4'b1000; tick(); ch_valid = '0;
        checks++; if (ch_ack !== 4'b1000) begin errors++; $display("FAIL t5_after_enable got=%h exp=8", ch_ack); end
        enable = 1'b0; tick();
    endtask

    task automatic test_saturate();
        logic [15:0] d0;
        enable = 1'b0;
        d0 = drop_cnt;
        ch_valid = 4'hF;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (drop_cnt !== d0 + 16'd20) begin errors++; $display("FAIL sat_wide got=%0d exp=%0d", drop_cnt, d0 + 16'd20); end
        checks++; if (drop_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_narrow got=%0d exp=15", drop_cnt_s); end
        tick();
        checks++; if (drop_cnt_s !== 4'd15) begin errors++; $display("FAIL sat_hold got=%0d exp=15", drop_cnt_s); end
        ch_valid = '0; enable = 1'b1; tick();
    endtask

    task automatic test_random();
        logic [NCH-1:0] p [0:21];
        logic [TW-1:0]  tv [0:21][0:NCH-1];
        int first [NCH];
        int win, tend, mn, total, captured, exp_fv_at, fv_first, acks;
        logic [NCH-1:0] present, exp_mask;
        logic [NCH*TW-1:0] exp_times;
        logic kept, exp_tmo;
        logic [15:0] d0;
        for (int ep = 0; ep < 40; ep++) begin
            win  = $urandom_range(2, 20);
            tend = win + 1;
            mn   = $urandom_range(0, 5);
            window_len = 32'(win);
            min_ch     = 5'(mn);
            for (int o = 0; o <= tend; o++) begin
                p[o] = '0;
                for (int c = 0; c < NCH; c++) begin
                    if ($urandom_range(0, tend) == 0) p[o][c] = 1'b1;
                    tv[o][c] = $urandom;
                end
            end
            if (p[0] == '0) p[0][$urandom_range(0, NCH-1)] = 1'b1;
            // Event-level expectation: first report per channel wins, window ends at tend.
            total = 0; present = '0; exp_times = '0;
            for (int c = 0; c < NCH; c++) first[c] = -1;
            for (int o = 0; o <= tend; o++)
                for (int c = 0; c < NCH; c++)
                    if (p[o][c]) begin
                        total++;
                        if (first[c] < 0) begin
                            first[c] = o;
                            present[c] = 1'b1;
                            exp_times[c*TW +: TW] = tv[o][c];
                        end
                    end
            captured = popc(present);
            if (captured == NCH) begin
                exp_fv_at = 0;
                for (int c = 0; c < NCH; c++) if (first[c] > exp_fv_at) exp_fv_at = first[c];
                kept = 1'b1; exp_tmo = 1'b0;
            end else begin
                exp_fv_at = tend;
                kept = (captured >= ((mn == 0) ? 1 : mn));
                exp_tmo = 1'b1;
            end
            exp_mask = kept ? present : '0;
            if (!kept) begin exp_times = '0; exp_fv_at = -1; end

            d0 = drop_cnt; acks = 0; fv_first = -1;
            for (int o = 0; o <= tend + 2; o++) begin
                ch_valid = (o <= tend) ? p[o] : '0;
                for (int c = 0; c < NCH; c++) set_time(c, (o <= tend) ? tv[o][c] : 32'h0);
                tick();
                acks += popc(ch_ack);
                if (frame_valid && fv_first < 0) fv_first = o;
            end
            ch_valid = '0;
            checks++; if (fv_first != exp_fv_at) begin errors++; $display("FAIL rnd%0d_fv_time got=%0d exp=%0d", ep, fv_first, exp_fv_at); end
            checks++; if (frame_mask !== exp_mask || (kept && frame_tmo !== exp_tmo)) begin errors++; $display("FAIL rnd%0d_mask got=%h tmo=%0b exp=%h tmo=%0b", ep, frame_mask, frame_tmo, exp_mask, exp_tmo); end
            checks++; if (frame_times !== exp_times) begin errors++; $display("FAIL rnd%0d_times got=%h exp=%h", ep, frame_times, exp_times); end
            checks++; if (drop_cnt !== d0 + 16'(total - captured)) begin errors++; $display("FAIL rnd%0d_drops got=%0d exp=%0d", ep, drop_cnt, d0 + 16'(total - captured)); end
            checks++; if (acks != captured) begin errors++; $display("FAIL rnd%0d_acks got=%0d exp=%0d", ep, acks, captured); end
            if (kept) begin
                frame_ack = 1'b1; tick(); frame_ack = 1'b0;
                checks++; if (frame_valid !== 1'b0 || frame_mask !== 4'h0) begin errors++; $display("FAIL rnd%0d_release got fv=%0b mask=%h", ep, frame_valid, frame_mask); end
            end
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_frame();
        test_timeout_keep();
        test_timeout_discard();
        test_duplicates();
        test_reset_enable();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
